// File: rtl/calc1_pkg.sv
// Shared types and defaults for the calc1 request front-end.
// Used by the per-port capture FSM and the collector/arbiter top.
package calc1_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_CMD_W  = 4;
    localparam int unsigned NUM_PORTS  = 4;

    typedef enum logic [3:0] {
        CMD_NOP = 4'd0,
        CMD_ADD = 4'd1,
        CMD_SUB = 4'd2,
        CMD_SHL = 4'd5,
        CMD_SHR = 4'd6
    } cmd_e;

    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_OK   = 2'd1,
        RESP_ERR  = 2'd2
    } resp_e;

    typedef enum logic [1:0] {
        StIdle,
        StOp2,
        StPend,
        StIssued
    } port_state_e;

    function automatic logic [1:0] rr_next(input logic [1:0] ptr);
        return ptr + 2'd1;
    endfunction

endpackage

// File: rtl/calc1_req_capture.sv
// One request port: assembles the two-cycle cmd/op1, op2 request, holds it until issued,
// and blocks further requests until the response stage reports done.
module calc1_req_capture
    import calc1_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned CMD_W  = DEF_CMD_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [CMD_W-1:0]  cmd_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              issue_i,
    input  logic              resp_done_i,
    output logic              pend_o,
    output logic              busy_o,
    output logic              proto_err_o,
    output logic [CMD_W-1:0]  cmd_o,
    output logic [DATA_W-1:0] op1_o,
    output logic [DATA_W-1:0] op2_o
);

    port_state_e       state_q, state_d;
    logic [CMD_W-1:0]  cmd_q, cmd_d;
    logic [DATA_W-1:0] op1_q, op1_d;
    logic [DATA_W-1:0] op2_q, op2_d;
    logic              err_q, err_d;
    logic              new_cmd;

    assign new_cmd = (cmd_i != '0);

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        err_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (new_cmd) begin
                    state_d = StOp2;
                    cmd_d   = cmd_i;
                    op1_d   = data_i;
                end
            end
            StOp2: begin
                // The second beat is always operand2, even if cmd is (illegally) nonzero.
                state_d = StPend;
                op2_d   = data_i;
                err_d   = new_cmd;
            end
            StPend: begin
                if (issue_i) begin
                    state_d = StIssued;
                end
                err_d = new_cmd;
            end
            StIssued: begin
                if (resp_done_i) begin
                    if (new_cmd) begin
                        state_d = StOp2;
                        cmd_d   = cmd_i;
                        op1_d   = data_i;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    err_d = new_cmd;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cmd_q   <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            err_q   <= err_d;
        end
    end

    assign pend_o      = (state_q == StPend);
    assign busy_o      = (state_q != StIdle);
    assign proto_err_o = err_q;
    assign cmd_o       = cmd_q;
    assign op1_o       = op1_q;
    assign op2_o       = op2_q;

endmodule

// File: rtl/calc1_req_collector.sv
// Collects two-cycle requests from four ports and issues them round-robin to the calc1 core
// over a registered valid/ready interface.
module calc1_req_collector
    import calc1_pkg::*;
#(
    parameter int unsigned DATA_W       = DEF_DATA_W,
    parameter int unsigned CMD_W        = DEF_CMD_W,
    parameter int unsigned RR_RESET_PTR = 0
) (
    input  logic              c_clk,
    input  logic              reset,
    input  logic [CMD_W-1:0]  req1_cmd_in,
    input  logic [DATA_W-1:0] req1_data_in,
    input  logic [CMD_W-1:0]  req2_cmd_in,
    input  logic [DATA_W-1:0] req2_data_in,
    input  logic [CMD_W-1:0]  req3_cmd_in,
    input  logic [DATA_W-1:0] req3_data_in,
    input  logic [CMD_W-1:0]  req4_cmd_in,
    input  logic [DATA_W-1:0] req4_data_in,
    input  logic              out_ready,
    input  logic [3:0]        resp_done,
    output logic              out_valid,
    output logic [1:0]        out_port,
    output logic [CMD_W-1:0]  out_cmd,
    output logic [DATA_W-1:0] out_op1,
    output logic [DATA_W-1:0] out_op2,
    output logic [3:0]        port_busy,
    output logic [3:0]        proto_err
);

    localparam logic [1:0] RrResetPtr = RR_RESET_PTR[1:0];

    logic [CMD_W-1:0]  port_cmd_in  [NUM_PORTS];
    logic [DATA_W-1:0] port_data_in [NUM_PORTS];
    logic [CMD_W-1:0]  cap_cmd      [NUM_PORTS];
    logic [DATA_W-1:0] cap_op1      [NUM_PORTS];
    logic [DATA_W-1:0] cap_op2      [NUM_PORTS];
    logic [3:0]        pend;
    logic [3:0]        issue;
    logic [3:0]        busy;
    logic [3:0]        err;

    logic              out_valid_q, out_valid_d;
    logic [1:0]        out_port_q, out_port_d;
    logic [CMD_W-1:0]  out_cmd_q, out_cmd_d;
    logic [DATA_W-1:0] out_op1_q, out_op1_d;
    logic [DATA_W-1:0] out_op2_q, out_op2_d;
    logic [1:0]        rr_ptr_q, rr_ptr_d;

    logic              handshake;
    logic              can_load;
    logic [3:0]        cand;
    logic              grant_vld;
    logic [1:0]        grant_idx;
    logic [1:0]        scan_idx;

    assign port_cmd_in[0]  = req1_cmd_in;
    assign port_cmd_in[1]  = req2_cmd_in;
    assign port_cmd_in[2]  = req3_cmd_in;
    assign port_cmd_in[3]  = req4_cmd_in;
    assign port_data_in[0] = req1_data_in;
    assign port_data_in[1] = req2_data_in;
    assign port_data_in[2] = req3_data_in;
    assign port_data_in[3] = req4_data_in;

    assign handshake = out_valid_q && out_ready;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        assign issue[p] = handshake && (out_port_q == 2'(p));

        calc1_req_capture #(
            .DATA_W (DATA_W),
            .CMD_W  (CMD_W)
        ) u_capture (
            .clk_i       (c_clk),
            .rst_i       (reset),
            .cmd_i       (port_cmd_in[p]),
            .data_i      (port_data_in[p]),
            .issue_i     (issue[p]),
            .resp_done_i (resp_done[p]),
            .pend_o      (pend[p]),
            .busy_o      (busy[p]),
            .proto_err_o (err[p]),
            .cmd_o       (cap_cmd[p]),
            .op1_o       (cap_op1[p]),
            .op2_o       (cap_op2[p])
        );
    end

    // The port completing its handshake this edge is still PEND; keep it out of the race.
    assign cand     = pend & ~issue;
    assign can_load = !out_valid_q || out_ready;

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = rr_ptr_q;
        scan_idx  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            scan_idx = rr_ptr_q + 2'(i);
            if (!grant_vld && cand[scan_idx]) begin
                grant_vld = 1'b1;
                grant_idx = scan_idx;
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_port_d  = out_port_q;
        out_cmd_d   = out_cmd_q;
        out_op1_d   = out_op1_q;
        out_op2_d   = out_op2_q;
        rr_ptr_d    = rr_ptr_q;
        if (can_load) begin
            if (grant_vld) begin
                out_valid_d = 1'b1;
                out_port_d  = grant_idx;
                out_cmd_d   = cap_cmd[grant_idx];
                out_op1_d   = cap_op1[grant_idx];
                out_op2_d   = cap_op2[grant_idx];
                rr_ptr_d    = rr_next(grant_idx);
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge c_clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_port_q  <= '0;
            out_cmd_q   <= '0;
            out_op1_q   <= '0;
            out_op2_q   <= '0;
            rr_ptr_q    <= RrResetPtr;
        end else begin
            out_valid_q <= out_valid_d;
            out_port_q  <= out_port_d;
            out_cmd_q   <= out_cmd_d;
            out_op1_q   <= out_op1_d;
            out_op2_q   <= out_op2_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_port  = out_port_q;
    assign out_cmd   = out_cmd_q;
    assign out_op1   = out_op1_q;
    assign out_op2   = out_op2_q;
    assign port_busy = busy;
    assign proto_err = err;

endmodule

// File: tb/tb_calc1_req_collector.sv
// Directed bench for calc1_req_collector with an issue scoreboard.
module tb_calc1_req_collector;

    logic        c_clk;
    logic        reset;
    logic [3:0]  cmd_a  [4];
    logic [31:0] data_a [4];
    logic        out_ready;
    logic [3:0]  resp_done;
    logic        out_valid;
    logic [1:0]  out_port;
    logic [3:0]  out_cmd;
    logic [31:0] out_op1;
    logic [31:0] out_op2;
    logic [3:0]  port_busy;
    logic [3:0]  proto_err;

    int total = 0;
    int bad   = 0;
    logic [69:0] exp_q [$];

    calc1_req_collector #(
        .DATA_W       (32),
        .CMD_W        (4),
        .RR_RESET_PTR (0)
    ) dut (
        .c_clk        (c_clk),
        .reset        (reset),
        .req1_cmd_in  (cmd_a[0]),
        .req1_data_in (data_a[0]),
        .req2_cmd_in  (cmd_a[1]),
        .req2_data_in (data_a[1]),
        .req3_cmd_in  (cmd_a[2]),
        .req3_data_in (data_a[2]),
        .req4_cmd_in  (cmd_a[3]),
        .req4_data_in (data_a[3]),
        .out_ready    (out_ready),
        .resp_done    (resp_done),
        .out_valid    (out_valid),
        .out_port     (out_port),
        .out_cmd      (out_cmd),
        .out_op1      (out_op1),
        .out_op2      (out_op2),
        .port_busy    (port_busy),
        .proto_err    (proto_err)
    );

    initial c_clk = 1'b0;
    always #5 c_clk = ~c_clk;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Scoreboard check of any handshake about to happen, then advance one edge.
    task automatic tick();
        logic [69:0] e;
        @(negedge c_clk);
        if (out_valid && out_ready && !reset) begin
            total++;
            assert (exp_q.size() != 0) else begin
                bad++;
                $error("FAIL issue_unexpected: observed port=%0d cmd=%0h, expected no issue",
                       out_port, out_cmd);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("issue_payload", {10'd0, out_port, out_cmd, out_op1, out_op2}, {10'd0, e});
            end
        end
        @(posedge c_clk);
        #1;
    endtask

    task automatic send(input int p, input logic [3:0] c, input logic [31:0] a,
                        input logic [31:0] b);
        cmd_a[p]  = c;
        data_a[p] = a;
        tick();
        cmd_a[p]  = '0;
        data_a[p] = b;
        tick();
        data_a[p] = '0;
        exp_q.push_back({2'(p), c, a, b});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        reset     = 1'b1;
        out_ready = 1'b0;
        resp_done = '0;
        for (int i = 0; i < 4; i++) begin
            cmd_a[i]  = '0;
            data_a[i] = '0;
        end
        tick();
        tick();
        reset = 1'b0;
        chk("reset_state", {out_valid, out_port, out_cmd, out_op1, out_op2, port_busy, proto_err},
            80'd0);

        // 1: single request latency and payload
        out_ready = 1'b1;
        send(0, 4'd1, 32'h0000_0005, 32'h0000_0003);
        chk("t1_latency_nv", {79'd0, out_valid}, 80'd0);
        chk("t1_busy_op2", {76'd0, port_busy}, 80'h1);
        tick();
        chk("t1_issue", {out_valid, out_port, out_cmd, out_op1, out_op2},
            {1'b1, 2'd0, 4'd1, 32'd5, 32'd3});
        tick();
        chk("t1_after_hs", {out_valid, port_busy}, {1'b0, 4'b0001});
        tick();
        chk("t1_busy_held", {76'd0, port_busy}, 80'h1);
        resp_done = 4'b0001;
        tick();
        resp_done = '0;
        chk("t1_busy_clear", {76'd0, port_busy}, 80'h0);
        chk("t1_sb_empty", 80'(exp_q.size()), 80'd0);

        // 2: all four ports together, two rounds
        do_reset();
        for (int r = 0; r < 2; r++) begin
            for (int p = 0; p < 4; p++) begin
                cmd_a[p]  = 4'(p + 1);
                data_a[p] = 32'h10 + 32'(p) + 32'(r * 256);
            end
            tick();
            for (int p = 0; p < 4; p++) begin
                cmd_a[p]  = '0;
                data_a[p] = 32'h20 + 32'(p) + 32'(r * 256);
                exp_q.push_back({2'(p), 4'(p + 1), 32'h10 + 32'(p) + 32'(r * 256),
                                 32'h20 + 32'(p) + 32'(r * 256)});
            end
            tick();
            for (int p = 0; p < 4; p++) data_a[p] = '0;
            for (int p = 0; p < 4; p++) begin
                tick();
                chk("t2_order", {77'd0, out_valid, out_port}, {77'd0, 1'b1, 2'(p)});
            end
            tick();
            chk("t2_done", {75'd0, out_valid, port_busy}, {75'd0, 1'b0, 4'hF});
            resp_done = 4'hF;
            tick();
            resp_done = '0;
            chk("t2_busy_clear", {76'd0, port_busy}, 80'h0);
        end
        chk("t2_sb_empty", 80'(exp_q.size()), 80'd0);

        // 3: backpressure holds the payload; port 3 waits behind port 2
        out_ready = 1'b0;
        send(1, 4'd2, 32'h0000_AAAA, 32'h0000_BBBB);
        for (int i = 0; i < 5; i++) begin
            if (i == 0) begin
                cmd_a[2]  = 4'd6;
                data_a[2] = 32'h33;
            end else if (i == 1) begin
                cmd_a[2]  = '0;
                data_a[2] = 32'h44;
                exp_q.push_back({2'd2, 4'd6, 32'h33, 32'h44});
            end else begin
                data_a[2] = '0;
            end
            tick();
            chk("t3_hold", {out_valid, out_port, out_cmd, out_op1, out_op2},
                {1'b1, 2'd1, 4'd2, 32'hAAAA, 32'hBBBB});
        end
        out_ready = 1'b1;
        tick();
        chk("t3_next", {77'd0, out_valid, out_port}, {77'd0, 1'b1, 2'd2});
        tick();
        chk("t3_idle", {79'd0, out_valid}, 80'd0);
        resp_done = 4'b0110;
        tick();
        resp_done = '0;
        chk("t3_sb_empty", 80'(exp_q.size()), 80'd0);

        // 4: protocol error while issued, then back-to-back accept on resp_done
        send(2, 4'd1, 32'd7, 32'd8);
        tick();
        tick();
        cmd_a[2]  = 4'd2;
        data_a[2] = 32'h99;
        tick();
        cmd_a[2]  = '0;
        data_a[2] = '0;
        chk("t4_err_pulse", {75'd0, out_valid, proto_err}, {75'd0, 1'b0, 4'b0100});
        tick();
        chk("t4_err_clear", {71'd0, out_valid, proto_err, port_busy},
            {71'd0, 1'b0, 4'b0000, 4'b0100});
        resp_done = 4'b0100;
        cmd_a[2]  = 4'd5;
        data_a[2] = 32'h55;
        tick();
        resp_done = '0;
        cmd_a[2]  = '0;
        data_a[2] = 32'h66;
        exp_q.push_back({2'd2, 4'd5, 32'h55, 32'h66});
        chk("t4_b2b_noerr", {72'd0, proto_err, port_busy}, {72'd0, 4'b0000, 4'b0100});
        tick();
        data_a[2] = '0;
        chk("t4_noerr_op2", {76'd0, proto_err}, 80'd0);
        tick();
        chk("t4_reissue", {73'd0, out_valid, out_port, out_cmd}, {73'd0, 1'b1, 2'd2, 4'd5});
        tick();
        resp_done = 4'b0100;
        tick();
        resp_done = '0;
        chk("t4_sb_empty", 80'(exp_q.size()), 80'd0);

        // 5: reset mid-operation
        out_ready = 1'b0;
        send(0, 4'd1, 32'hA, 32'hB);
        cmd_a[1]  = 4'd2;
        data_a[1] = 32'h1;
        tick();
        cmd_a[1]  = '0;
        data_a[1] = '0;
        chk("t5_pre_reset", {75'd0, out_valid, port_busy}, {75'd0, 1'b1, 4'b0011});
        do_reset();
        chk("t5_reset_state",
            {out_valid, out_port, out_cmd, out_op1, out_op2, port_busy, proto_err}, 80'd0);
        resp_done = 4'hF;
        tick();
        resp_done = '0;
        chk("t5_stale_resp", {75'd0, out_valid, port_busy}, 80'd0);
        out_ready = 1'b1;
        send(3, 4'd6, 32'h1234, 32'h5678);
        tick();
        chk("t5_new_issue", {out_valid, out_port, out_cmd, out_op1, out_op2},
            {1'b1, 2'd3, 4'd6, 32'h1234, 32'h5678});
        tick();
        resp_done = 4'b1000;
        tick();
        resp_done = '0;

        // 6: stray resp_done and nop traffic
        resp_done = 4'b0010;
        for (int p = 0; p < 4; p++) data_a[p] = $urandom;
        tick();
        resp_done = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_quiet", {71'd0, out_valid, port_busy, proto_err}, 80'd0);
        end
        for (int p = 0; p < 4; p++) data_a[p] = '0;
        chk("final_sb_empty", 80'(exp_q.size()), 80'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
